// File: rtl/if_stage_pkg.sv
// Shared constants and types for the instruction-fetch stage.
package if_stage_pkg;

  localparam logic        RST_ENABLE    = 1'b1;
  localparam logic        CHIP_ENABLE   = 1'b1;
  localparam logic        CHIP_DISABLE  = 1'b0;
  localparam logic [31:0] ZERO_WORD     = 32'h0000_0000;
  // addi x0, x0, 0
  localparam logic [31:0] NOP_INST      = 32'h0000_0013;
  localparam int unsigned INST_ADDR_BUS = 32;
  localparam int unsigned INST_BUS      = 32;

  // DIS: ROM disabled right after reset; RUN: fetching.
  typedef enum logic {StDis, StRun} fetch_state_e;

endpackage

// File: rtl/if_stage_pc_reg.sv
// PC generator: owns pc, the DIS/RUN state, the pending redirect and the misalign pulse.
module pc_reg
  import if_stage_pkg::*;
#(
  parameter int unsigned       ADDR_W   = INST_ADDR_BUS,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              branch_flag_i,
  input  logic [ADDR_W-1:0] branch_target_i,
  output logic              rom_ce_o,
  output logic [ADDR_W-1:0] rom_addr_o,
  output logic              redirect_now,
  output logic              misalign_o
);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              pend_q, pend_d;
  logic [ADDR_W-1:0] pend_target_q, pend_target_d;
  logic              misalign_q, misalign_d;

  // Next-state: hold under stall (remembering the latest redirect), otherwise redirect or step.
  always_comb begin
    state_d       = StRun;
    pc_d          = pc_q;
    pend_d        = pend_q;
    pend_target_d = pend_target_q;
    misalign_d    = 1'b0;
    if (state_q == StRun) begin
      if (stall) begin
        if (branch_flag_i) begin
          pend_d        = 1'b1;
          pend_target_d = branch_target_i;
        end
      end else begin
        pend_d = 1'b0;
        if (branch_flag_i) begin
          pc_d       = {branch_target_i[ADDR_W-1:2], 2'b00};
          misalign_d = |branch_target_i[1:0];
        end else if (pend_q) begin
          pc_d       = {pend_target_q[ADDR_W-1:2], 2'b00};
          misalign_d = |pend_target_q[1:0];
        end else begin
          // Wraps modulo 2^ADDR_W.
          pc_d = pc_q + ADDR_W'(4);
        end
      end
    end
  end

  // State register with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst == RST_ENABLE) begin
      state_q       <= StDis;
      pc_q          <= RESET_PC;
      pend_q        <= 1'b0;
      pend_target_q <= '0;
      misalign_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      pend_q        <= pend_d;
      pend_target_q <= pend_target_d;
      misalign_q    <= misalign_d;
    end
  end

  // ROM interface and redirect strobe for the IF/ID register.
  always_comb begin
    rom_ce_o     = (state_q == StRun) ? CHIP_ENABLE : CHIP_DISABLE;
    rom_addr_o   = pc_q;
    redirect_now = (state_q == StRun) && (branch_flag_i || pend_q);
    misalign_o   = misalign_q;
  end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC generation plus the IF/ID pipeline register.
module if_stage
  import if_stage_pkg::*;
#(
  parameter int unsigned       ADDR_W   = INST_ADDR_BUS,
  parameter int unsigned       INST_W   = INST_BUS,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_if,
  input  logic              stall_id,
  input  logic              branch_flag_i,
  input  logic [ADDR_W-1:0] branch_target_i,
  output logic              rom_ce_o,
  output logic [ADDR_W-1:0] rom_addr_o,
  input  logic [INST_W-1:0] rom_inst_i,
  output logic [ADDR_W-1:0] id_pc_o,
  output logic [INST_W-1:0] id_inst_o,
  output logic              id_valid_o,
  output logic              misalign_o
);

  localparam logic [INST_W-1:0] NOP = INST_W'(NOP_INST);

  logic redirect_now;

  pc_reg #(
    .ADDR_W  (ADDR_W),
    .RESET_PC(RESET_PC)
  ) u_pc_reg (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall_if | stall_id),
    .branch_flag_i  (branch_flag_i),
    .branch_target_i(branch_target_i),
    .rom_ce_o       (rom_ce_o),
    .rom_addr_o     (rom_addr_o),
    .redirect_now   (redirect_now),
    .misalign_o     (misalign_o)
  );

  // IF/ID register: hold on stall_id, bubble on stall_if or wrong-path fetch, else capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst == RST_ENABLE) begin
      id_pc_o    <= '0;
      id_inst_o  <= NOP;
      id_valid_o <= 1'b0;
    end else if (rom_ce_o == CHIP_DISABLE) begin
      id_pc_o    <= rom_addr_o;
      id_inst_o  <= NOP;
      id_valid_o <= 1'b0;
    end else if (stall_id) begin
      id_pc_o    <= id_pc_o;
      id_inst_o  <= id_inst_o;
      id_valid_o <= id_valid_o;
    end else if (stall_if || redirect_now) begin
      id_pc_o    <= rom_addr_o;
      id_inst_o  <= NOP;
      id_valid_o <= 1'b0;
    end else begin
      id_pc_o    <= rom_addr_o;
      id_inst_o  <= rom_inst_i;
      id_valid_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage with an expectation queue checked one edge after each drive.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_if, stall_id, branch_flag_i;
  logic [31:0] branch_target_i;
  logic        rom_ce_o;
  logic [31:0] rom_addr_o;
  logic [31:0] rom_inst_i;
  logic [31:0] id_pc_o;
  logic [31:0] id_inst_o;
  logic        id_valid_o;
  logic        misalign_o;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        ce;
    logic [31:0] pc;
    logic        valid;
    logic [31:0] id_pc;
    logic        mis;
    string       tag;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  // ROM: distinct word per address.
  assign rom_inst_i = 32'hC000_0000 ^ rom_addr_o;

  if_stage dut (
    .clk            (clk),
    .rst            (rst),
    .stall_if       (stall_if),
    .stall_id       (stall_id),
    .branch_flag_i  (branch_flag_i),
    .branch_target_i(branch_target_i),
    .rom_ce_o       (rom_ce_o),
    .rom_addr_o     (rom_addr_o),
    .rom_inst_i     (rom_inst_i),
    .id_pc_o        (id_pc_o),
    .id_inst_o      (id_inst_o),
    .id_valid_o     (id_valid_o),
    .misalign_o     (misalign_o)
  );

  task automatic check(input exp_t e);
    logic [31:0] exp_inst;
    exp_inst = e.valid ? (32'hC000_0000 ^ e.id_pc) : 32'h0000_0013;
    total += 6;
    assert (rom_ce_o === e.ce) else begin
      bad++; $error("FAIL %s ce got=%0h want=%0h", e.tag, rom_ce_o, e.ce);
    end
    assert (rom_addr_o === e.pc) else begin
      bad++; $error("FAIL %s pc got=%0h want=%0h", e.tag, rom_addr_o, e.pc);
    end
    assert (id_valid_o === e.valid) else begin
      bad++; $error("FAIL %s valid got=%0h want=%0h", e.tag, id_valid_o, e.valid);
    end
    assert (id_pc_o === e.id_pc) else begin
      bad++; $error("FAIL %s id_pc got=%0h want=%0h", e.tag, id_pc_o, e.id_pc);
    end
    assert (id_inst_o === exp_inst) else begin
      bad++; $error("FAIL %s id_inst got=%0h want=%0h", e.tag, id_inst_o, exp_inst);
    end
    assert (misalign_o === e.mis) else begin
      bad++; $error("FAIL %s misalign got=%0h want=%0h", e.tag, misalign_o, e.mis);
    end
  endtask

  // Drive one cycle of inputs, queue the post-edge expectation, then pop and compare.
  task automatic cyc(input string tag, input logic sif, input logic sid, input logic br,
                     input logic [31:0] tgt, input logic ce, input logic [31:0] pc,
                     input logic v, input logic [31:0] idpc, input logic mis);
    exp_t e;
    stall_if        = sif;
    stall_id        = sid;
    branch_flag_i   = br;
    branch_target_i = tgt;
    e.ce = ce; e.pc = pc; e.valid = v; e.id_pc = idpc; e.mis = mis; e.tag = tag;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check(e);
  endtask

  task automatic check_reset(input string tag);
    exp_t e;
    e.ce = 1'b0; e.pc = 32'h0; e.valid = 1'b0; e.id_pc = 32'h0; e.mis = 1'b0; e.tag = tag;
    sb.push_back(e);
    e = sb.pop_front();
    check(e);
  endtask

  initial begin
    rst = 1'b1;
    stall_if = 1'b0; stall_id = 1'b0; branch_flag_i = 1'b0; branch_target_i = 32'h0;
    #2;
    check_reset("reset");
    @(negedge clk);
    rst = 1'b0;

    // Startup and sequential fetch.
    cyc("leave_dis", 0, 0, 0, 32'h0, 1, 32'h00, 0, 32'h00, 0);
    cyc("seq0",      0, 0, 0, 32'h0, 1, 32'h04, 1, 32'h00, 0);
    cyc("seq1",      0, 0, 0, 32'h0, 1, 32'h08, 1, 32'h04, 0);
    cyc("seq2",      0, 0, 0, 32'h0, 1, 32'h0C, 1, 32'h08, 0);
    cyc("seq3",      0, 0, 0, 32'h0, 1, 32'h10, 1, 32'h0C, 0);
    // Unstalled branch.
    cyc("br40",      0, 0, 1, 32'h40, 1, 32'h40, 0, 32'h10, 0);
    cyc("br40_a",    0, 0, 0, 32'h0,  1, 32'h44, 1, 32'h40, 0);
    cyc("br40_b",    0, 0, 0, 32'h0,  1, 32'h48, 1, 32'h44, 0);
    // Branch during stall_if is held pending.
    cyc("sif1_br",   1, 0, 1, 32'h80, 1, 32'h48, 0, 32'h48, 0);
    cyc("sif2",      1, 0, 0, 32'h0,  1, 32'h48, 0, 32'h48, 0);
    cyc("sif3",      1, 0, 0, 32'h0,  1, 32'h48, 0, 32'h48, 0);
    cyc("pend_go",   0, 0, 0, 32'h0,  1, 32'h80, 0, 32'h48, 0);
    cyc("pend_a",    0, 0, 0, 32'h0,  1, 32'h84, 1, 32'h80, 0);
    cyc("pend_b",    0, 0, 0, 32'h0,  1, 32'h88, 1, 32'h84, 0);
    // stall_id freezes everything.
    cyc("sid1",      0, 1, 0, 32'h0,  1, 32'h88, 1, 32'h84, 0);
    cyc("sid2",      0, 1, 0, 32'h0,  1, 32'h88, 1, 32'h84, 0);
    cyc("sid_rel",   0, 0, 0, 32'h0,  1, 32'h8C, 1, 32'h88, 0);
    // Misaligned target.
    cyc("mis_go",    0, 0, 1, 32'h102, 1, 32'h100, 0, 32'h8C, 1);
    cyc("mis_end",   0, 0, 0, 32'h0,   1, 32'h104, 1, 32'h100, 0);
    // Wraparound at the top of the address space.
    cyc("wrap_br",   0, 0, 1, 32'hFFFF_FFFC, 1, 32'hFFFF_FFFC, 0, 32'h104, 0);
    cyc("wrap",      0, 0, 0, 32'h0, 1, 32'h0000_0000, 1, 32'hFFFF_FFFC, 0);
    cyc("wrap_a",    0, 0, 0, 32'h0, 1, 32'h0000_0004, 1, 32'h0000_0000, 0);
    // Later pending redirect overwrites an earlier one.
    cyc("ovr1",      0, 1, 1, 32'h200, 1, 32'h004, 1, 32'h000, 0);
    cyc("ovr2",      1, 0, 1, 32'h303, 1, 32'h004, 0, 32'h004, 0);
    cyc("ovr_go",    0, 0, 0, 32'h0,   1, 32'h300, 0, 32'h004, 1);
    cyc("ovr_a",     0, 0, 0, 32'h0,   1, 32'h304, 1, 32'h300, 0);
    // Asynchronous reset mid-stall with a redirect pending.
    cyc("pre_rst",   1, 0, 1, 32'h500, 1, 32'h304, 0, 32'h304, 0);
    #2;
    rst = 1'b1;
    #1;
    check_reset("async_rst");
    @(negedge clk);
    rst = 1'b0;
    cyc("rst_dis",   0, 0, 0, 32'h0, 1, 32'h00, 0, 32'h00, 0);
    cyc("rst_seq0",  0, 0, 0, 32'h0, 1, 32'h04, 1, 32'h00, 0);
    cyc("rst_seq1",  0, 0, 0, 32'h0, 1, 32'h08, 1, 32'h04, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Safety net against a hang.
  initial begin
    #100000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
